// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, serial FSM states
// and the signed-overflow helper used by the add/sub datapath.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_RSUB = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Overflow of X + Y': operands share a sign, sum differs.
    function automatic logic ovf(
        input logic xm,
        input logic ym,
        input logic sm
    );
        return (xm == ym) && (sm != xm);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit adder slice.
// Ports: x, y (DIGIT), cin -> s (DIGIT), cout.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y}
                     + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/sub/rsub/cmp unit with status flags.
// Ports: clk, rst_n, start/op/a/b in; ready, valid, result, flags out.
module addsub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t state, state_d;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] x, y, sum, sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] xk, yk, sk;
    logic             cout;
    logic             last;
    logic             acc;

    assign ready = (state != S_RUN);
    assign acc   = start && ready;
    assign last  = (cnt == CW'(NDIG - 1));
    assign xk    = x[cnt*DIGIT +: DIGIT];
    assign yk    = y[cnt*DIGIT +: DIGIT];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (xk),
        .y    (yk),
        .cin  (carry),
        .s    (sk),
        .cout (cout)
    );

    // Full sum as it will look after this edge, so flags
    // can be registered on the same edge as the last digit.
    always_comb begin
        sum_nx = sum;
        sum_nx[cnt*DIGIT +: DIGIT] = sk;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_ADD;
            x      <= '0;
            y      <= '0;
            sum    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            valid  <= 1'b0;
            result <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (acc) begin
            op_q  <= op;
            x     <= (op == OP_RSUB) ? b : a;
            y     <= (op == OP_ADD)  ? b :
                     (op == OP_RSUB) ? ~a : ~b;
            carry <= (op != OP_ADD);
            cnt   <= '0;
            valid <= 1'b0;
        end else if (state == S_RUN) begin
            sum   <= sum_nx;
            carry <= cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                valid  <= 1'b1;
                // Subtraction reports borrow, the inverse of carry.
                flag_c <= (op_q == OP_ADD) ? cout : ~cout;
                flag_v <= ovf(x[WIDTH-1], y[WIDTH-1],
                              sum_nx[WIDTH-1]);
                flag_z <= (sum_nx == '0);
                flag_n <= sum_nx[WIDTH-1];
                if (op_q != OP_CMP) result <= sum_nx;
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three configurations (8/2, 16/16, 16/4)
// checked against an arithmetic model plus literal expectations.
module tb_addsub_serial;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       st, rdy, vld, fc, fv, fz, fn;
    logic [2:0][1:0]  opv;
    logic [2:0][15:0] av, bv;
    logic [7:0]       r0;
    logic [15:0]      r1, r2;
    logic [2:0][19:0] expv;

    int errors = 0;
    int checks = 0;

    localparam int WID [3] = '{8, 16, 16};
    localparam int LAT [3] = '{4, 1, 4};

    addsub_serial #(.WIDTH(8), .DIGIT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .op(opv[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .ready(rdy[0]),
        .valid(vld[0]), .result(r0), .flag_c(fc[0]),
        .flag_v(fv[0]), .flag_z(fz[0]), .flag_n(fn[0])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .op(opv[1]),
        .a(av[1]), .b(bv[1]), .ready(rdy[1]),
        .valid(vld[1]), .result(r1), .flag_c(fc[1]),
        .flag_v(fv[1]), .flag_z(fz[1]), .flag_n(fn[1])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .op(opv[2]),
        .a(av[2]), .b(bv[2]), .ready(rdy[2]),
        .valid(vld[2]), .result(r2), .flag_c(fc[2]),
        .flag_v(fv[2]), .flag_z(fz[2]), .flag_n(fn[2])
    );

    function automatic logic [15:0] res(input int u);
        case (u)
            0:       return {8'h00, r0};
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    function automatic logic [3:0] flg(input int u);
        return {fc[u], fv[u], fz[u], fn[u]};
    endfunction

    // Returns {c, v, z, n, result} from plain integer arithmetic.
    function automatic logic [19:0] model(
        input int w, input logic [1:0] o,
        input logic [15:0] xa, input logic [15:0] xb,
        input logic [15:0] prev
    );
        longint m, ua, ub, full, sa, sb, sr, hi, lo;
        logic c, v, z, n;
        logic [15:0] r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(xa) & m;
        ub = longint'(xb) & m;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        sa = (ua > hi) ? ua - (m + 1) : ua;
        sb = (ub > hi) ? ub - (m + 1) : ub;
        case (o)
            OP_ADD: begin
                full = ua + ub; c = (full > m); sr = sa + sb;
            end
            OP_RSUB: begin
                full = ub - ua; c = (ub < ua); sr = sb - sa;
            end
            default: begin
                full = ua - ub; c = (ua < ub); sr = sa - sb;
            end
        endcase
        r = 16'(full & m);
        v = (sr > hi) || (sr < lo);
        z = (r == 16'h0);
        n = r[w-1];
        return {c, v, z, n, (o == OP_CMP) ? prev : r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 3; u++) begin
                if (vld[u]) begin
                    chk($sformatf("u%0d result", u),
                        32'(res(u)), 32'(expv[u][15:0]));
                    chk($sformatf("u%0d cvzn", u),
                        32'(flg(u)), 32'(expv[u][19:16]));
                end
            end
        end
    end

    task automatic issue(input int u, input logic [1:0] o,
                         input logic [15:0] x, input logic [15:0] y,
                         input bit hold);
        int n;
        int lat;
        logic [15:0] msk;
        msk = (u == 0) ? 16'h00FF : 16'hFFFF;
        n = 0;
        while (!rdy[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d ready before issue", u), 32'(rdy[u]), 1);
        @(negedge clk);
        st[u] = 1'b1; opv[u] = o;
        av[u] = x & msk; bv[u] = y & msk;
        @(posedge clk);
        #1;
        expv[u] = model(WID[u], o, x & msk, y & msk, expv[u][15:0]);
        lat = 0;
        for (int i = 1; i <= LAT[u] + 3; i++) begin
            @(negedge clk);
            st[u] = hold && (i < LAT[u]);
            av[u] = 16'($urandom) & msk;
            bv[u] = 16'($urandom) & msk;
            opv[u] = 2'($urandom);
            @(posedge clk);
            #1;
            if (vld[u]) begin
                lat = i;
                break;
            end
            chk($sformatf("u%0d ready in RUN", u), 32'(rdy[u]), 0);
        end
        chk($sformatf("u%0d latency", u), lat, LAT[u]);
        chk($sformatf("u%0d ready in DONE", u), 32'(rdy[u]), 1);
    endtask

    task automatic lit(input string nm, input logic [15:0] r,
                       input logic [3:0] f);
        chk({nm, " result"}, 32'(res(0)), 32'(r));
        chk({nm, " cvzn"}, 32'(flg(0)), 32'(f));
    endtask

    initial begin
        logic [1:0]  o;
        logic [15:0] x, y;
        st = '0; opv = '0; av = '0; bv = '0; expv = '0;
        #12;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d reset ready", u), 32'(rdy[u]), 1);
            chk($sformatf("u%0d reset valid", u), 32'(vld[u]), 0);
            chk($sformatf("u%0d reset result", u), 32'(res(u)), 0);
            chk($sformatf("u%0d reset flags", u), 32'(flg(u)), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, OP_SUB, 16'd10, 16'd5, 1'b0);
        lit("sub 10-5", 16'h05, 4'b0000);
        issue(0, OP_SUB, 16'hFF, 16'h7B, 1'b0);
        lit("sub FF-7B", 16'h84, 4'b0001);
        issue(0, OP_SUB, 16'h87, 16'h0A, 1'b0);
        lit("sub 87-0A", 16'h7D, 4'b0100);
        issue(0, OP_ADD, 16'hFF, 16'h01, 1'b0);
        lit("add FF+01", 16'h00, 4'b1010);
        issue(0, OP_ADD, 16'h7F, 16'h01, 1'b0);
        lit("add 7F+01", 16'h80, 4'b0101);
        issue(0, OP_CMP, 16'd5, 16'd10, 1'b0);
        lit("cmp 5,10", 16'h80, 4'b1001);
        issue(0, OP_RSUB, 16'd5, 16'd10, 1'b0);
        lit("rsub 10-5", 16'h05, 4'b0000);

        issue(0, OP_ADD, 16'h12, 16'h34, 1'b1);
        lit("add under start spam", 16'h46, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single valid held", 32'(vld[0]), 1);
        end

        @(negedge clk);
        st[0] = 1'b1; opv[0] = OP_SUB;
        av[0] = 16'h33; bv[0] = 16'h11;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort ready", 32'(rdy[0]), 1);
        chk("abort valid", 32'(vld[0]), 0);
        chk("abort result", 32'(res(0)), 0);
        chk("abort flags", 32'(flg(0)), 0);
        expv = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int u = 1; u < 3; u++) begin
            for (int k = 0; k < 1000; k++) begin
                o = 2'($urandom);
                x = 16'($urandom);
                y = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: x = y;
                    1: x = 16'h8000;
                    2: y = 16'hFFFF;
                    3: y = 16'h0000;
                    default: ;
                endcase
                issue(u, o, x, y, 1'b0);
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
